// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: FETCH issues imem_req until imem_ready, HOLD presents the word until stall drops.
// Two cycles per instruction minimum; redirect wins over everything. FETCH_ALIGN_CHECK_EN traps misaligned redirects.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic             o_imem_req,
    output logic [31:0]      o_imem_addr,
    input  logic             i_imem_ready,
    input  logic [31:0]      i_imem_rdata,
    input  logic             i_redirect_valid,
    input  logic [31:0]      i_redirect_pc,
    input  logic             i_stall,
    output logic             o_inst_valid,
    output logic [31:0]      o_inst,
    output logic [31:0]      o_inst_pc,
    output logic [CNT_W-1:0] o_inst_count,
    output logic             o_fault
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_FAULT} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [31:0]        r_pc;
    logic [31:0]        r_inst;
    logic [31:0]        r_inst_pc;
    logic [CNT_W-1:0]   r_count;
    logic [31:0]        w_redir_pc;
    logic               w_misaligned;
    logic               w_redirect;
    logic               w_fetch_done;
    logic               w_consume;

`ifdef FETCH_ALIGN_CHECK_EN
    assign w_redir_pc   = i_redirect_pc;
    assign w_misaligned = (i_redirect_pc[1:0] != 2'b00);
`else
    assign w_redir_pc   = i_redirect_pc & 32'hFFFF_FFFC;
    assign w_misaligned = 1'b0;
`endif

    // FAULT is sticky: redirects there are ignored until reset
    assign w_redirect   = i_redirect_valid && (r_state != S_FAULT);
    assign w_fetch_done = (r_state == S_FETCH) && i_imem_ready && !i_redirect_valid;
    assign w_consume    = (r_state == S_HOLD) && !i_stall && !i_redirect_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_redirect) begin
            w_next = w_misaligned ? S_FAULT : S_FETCH;
        end else begin
            case (r_state)
                S_IDLE:  w_next = S_FETCH;
                S_FETCH: if (i_imem_ready) w_next = S_HOLD;
                S_HOLD:  if (!i_stall) w_next = S_FETCH;
                S_FAULT: w_next = S_FAULT;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_imem_req   = (r_state == S_FETCH);
        o_inst_valid = (r_state == S_HOLD);
        o_fault      = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        o_fault      = (r_state == S_FAULT);
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc      <= RESET_PC;
            r_inst    <= 32'h0;
            r_inst_pc <= 32'h0;
            r_count   <= '0;
        end else begin
            if (w_redirect && !w_misaligned) begin
                r_pc <= w_redir_pc;
            end else if (w_fetch_done) begin
                r_inst    <= i_imem_rdata;
                r_inst_pc <= r_pc;
                r_pc      <= r_pc + 32'd4;
            end
            if (w_consume && (r_count != {CNT_W{1'b1}})) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_imem_addr  = r_pc;
    assign o_inst       = r_inst;
    assign o_inst_pc    = r_inst_pc;
    assign o_inst_count = r_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; consumed instructions are checked against a queue of expected pc/inst pairs.
module tb_fetch_sequencer;

    localparam int CW = 3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          imem_req;
    logic [31:0]   imem_addr;
    logic          imem_ready;
    logic [31:0]   imem_rdata;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          stall;
    logic          inst_valid;
    logic [31:0]   inst;
    logic [31:0]   inst_pc;
    logic [CW-1:0] inst_count;
    logic          fault;

    logic          use_fixed;
    logic [31:0]   fixed_word;
    exp_t          sb[$];
    int            checks;
    int            errors;

    fetch_sequencer #(.RESET_PC(32'h0), .CNT_W(CW)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .o_imem_req       (imem_req),
        .o_imem_addr      (imem_addr),
        .i_imem_ready     (imem_ready),
        .i_imem_rdata     (imem_rdata),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .i_stall          (stall),
        .o_inst_valid     (inst_valid),
        .o_inst           (inst),
        .o_inst_pc        (inst_pc),
        .o_inst_count     (inst_count),
        .o_fault          (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word = address ^ 0x12340000 unless a fixed word is forced
    always_comb imem_rdata = use_fixed ? fixed_word : (imem_addr ^ 32'h1234_0000);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] word);
        exp_t e;
        e.pc   = pc;
        e.inst = word;
        sb.push_back(e);
    endtask

    // Monitor: a consume handshake must match the oldest expected entry
    always @(negedge clk) begin
        if (!rst && inst_valid && !stall && !redirect_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL consume_unexpected: got pc %h with no expected entry", inst_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("consume_pc", inst_pc, e.pc);
                chk("consume_inst", inst, e.inst);
            end
        end
    end

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; imem_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        stall = 1'b0; use_fixed = 1'b0; fixed_word = 32'h0;
        step(); step();
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'h0, inst_valid}, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_count", {29'h0, inst_count}, 32'h0);
        chk("rst_fault", {31'h0, fault}, 32'h0);

        rst = 1'b0;
        step();
        chk("idle_to_fetch_req", {31'h0, imem_req}, 32'h1);

        // Back-to-back fetch 0,4,8 with ready tied high
        imem_ready = 1'b1;
        push(32'h0, 32'h1234_0000);
        push(32'h4, 32'h1234_0004);
        push(32'h8, 32'h1234_0008);
        for (int i = 0; i < 3; i++) begin
            chk("seq_req", {31'h0, imem_req}, 32'h1);
            chk("seq_addr", imem_addr, 32'(i * 4));
            step();
            chk("seq_valid", {31'h0, inst_valid}, 32'h1);
            chk("seq_hold_req", {31'h0, imem_req}, 32'h0);
            step();
        end
        chk("seq_count", {29'h0, inst_count}, 32'd3);
        chk("seq_next_addr", imem_addr, 32'hC);

        // Redirect to 0x10 while waiting, then a 3-cycle memory delay
        imem_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h10;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("wait_req", {31'h0, imem_req}, 32'h1);
            chk("wait_addr", imem_addr, 32'h10);
            step();
        end
        chk("wait_req4", {31'h0, imem_req}, 32'h1);
        chk("wait_addr4", imem_addr, 32'h10);
        use_fixed = 1'b1; fixed_word = 32'h8C01_0004;
        imem_ready = 1'b1;
        push(32'h10, 32'h8C01_0004);
        step();
        use_fixed = 1'b0;
        chk("wait_inst_pc", inst_pc, 32'h10);

        // Stall for 5 cycles in HOLD
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {31'h0, inst_valid}, 32'h1);
            chk("stall_req", {31'h0, imem_req}, 32'h0);
            chk("stall_inst", inst, 32'h8C01_0004);
            chk("stall_inst_pc", inst_pc, 32'h10);
            chk("stall_count", {29'h0, inst_count}, 32'd3);
            step();
        end
        stall = 1'b0;
        step();
        chk("unstall_count", {29'h0, inst_count}, 32'd4);
        chk("unstall_addr", imem_addr, 32'h14);
        chk("unstall_valid", {31'h0, inst_valid}, 32'h0);

        // Redirect coincident with imem_ready drops the data
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        step();
        redirect_valid = 1'b0;
        chk("redir_addr", imem_addr, 32'h40);
        chk("redir_valid", {31'h0, inst_valid}, 32'h0);
        chk("redir_inst_pc", inst_pc, 32'h10);
        chk("redir_count", {29'h0, inst_count}, 32'd4);
        push(32'h40, 32'h1234_0040);
        step(); step();
        chk("after_redir_count", {29'h0, inst_count}, 32'd5);
        chk("after_redir_addr", imem_addr, 32'h44);

        // Redirect in HOLD with stall low discards the held word
        step();
        chk("hold_redir_valid_before", {31'h0, inst_valid}, 32'h1);
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        step();
        redirect_valid = 1'b0;
        chk("hold_redir_count", {29'h0, inst_count}, 32'd5);
        chk("hold_redir_valid", {31'h0, inst_valid}, 32'h0);
        chk("hold_redir_addr", imem_addr, 32'h80);

        // Misaligned redirect
        imem_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h42;
        step();
`ifdef FETCH_ALIGN_CHECK_EN
        redirect_pc = 32'h100;
        for (int i = 0; i < 3; i++) begin
            chk("fault_flag", {31'h0, fault}, 32'h1);
            chk("fault_req", {31'h0, imem_req}, 32'h0);
            chk("fault_valid", {31'h0, inst_valid}, 32'h0);
            step();
        end
        redirect_valid = 1'b0;
`else
        redirect_valid = 1'b0;
        chk("align_addr", imem_addr, 32'h40);
        chk("align_fault", {31'h0, fault}, 32'h0);
        chk("align_req", {31'h0, imem_req}, 32'h1);
`endif

        // Reset overrides a pending fetch (or FAULT)
        rst = 1'b1;
        step();
        chk("rst2_addr", imem_addr, 32'h0);
        chk("rst2_req", {31'h0, imem_req}, 32'h0);
        chk("rst2_count", {29'h0, inst_count}, 32'd0);
        chk("rst2_fault", {31'h0, fault}, 32'h0);
        rst = 1'b0;
        step();

        // PC wrap from 0xFFFFFFFC
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        imem_ready = 1'b1;
        push(32'hFFFF_FFFC, 32'hEDCB_FFFC);
        step();
        chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
        step();
        chk("wrap_next_addr", imem_addr, 32'h0);
        chk("wrap_count", {29'h0, inst_count}, 32'd1);

        // Counter saturates at all-ones
        for (int k = 0; k < 7; k++) begin
            push(32'(k * 4), 32'(k * 4) ^ 32'h1234_0000);
            step(); step();
            chk("sat_count", {29'h0, inst_count}, (k + 2 > 7) ? 32'd7 : 32'(k + 2));
        end

        imem_ready = 1'b0;
        step(); step();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter CNT_W, default 16: width of the issued-instruction counter.
REQ-003 Clock  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset, sampled on the rising edge of Clock.
REQ-005 imem_req  output  1  instruction-memory read request.
REQ-006 imem_addr  output  32  word address presented with imem_req.
REQ-007 imem_ready  input  1  memory has valid imem_rdata this cycle.
REQ-008 imem_rdata  input  32  instruction word from memory.
REQ-009 redirect_valid  input  1  taken jump, jr or branch from decode/execute.
REQ-010 redirect_pc  input  32  target PC accompanying redirect_valid.
REQ-011 stall  input  1  downstream cannot accept the held instruction.
REQ-012 inst_valid  output  1  inst and inst_pc are valid.
REQ-013 inst  output  32  fetched instruction.
REQ-014 inst_pc  output  32  address of inst.
REQ-015 inst_count  output  CNT_W  instructions consumed downstream; saturates at all-ones.
REQ-016 fault  output  1  misaligned redirect detected (see Configuration).

Function
REQ-017 The block SHALL implement states IDLE, FETCH, HOLD and FAULT.
REQ-018 IDLE SHALL last exactly one cycle after reset, then go to FETCH.
REQ-019 In FETCH: imem_req=1 and imem_addr=pc; the block SHALL wait any number of cycles for imem_ready.
REQ-020 On FETCH with imem_ready=1 and no redirect: inst<=imem_rdata, inst_pc<=pc, pc<=pc+4 (mod 2^32), inst_valid=1 from the next cycle, next state HOLD.
REQ-021 In HOLD: imem_req=0; inst, inst_pc and inst_valid SHALL stay stable while stall=1.
REQ-022 In HOLD with stall=0: the instruction is consumed, inst_count increments (saturating), inst_valid=0 next cycle, next state FETCH.
REQ-023 redirect_valid=1 in IDLE, FETCH or HOLD SHALL take priority over all other events: pc<=redirect_pc, inst_valid=0 next cycle, next state FETCH, inst_count unchanged.
REQ-024 A redirect in the same cycle as imem_ready SHALL discard imem_rdata.
REQ-025 A redirect in HOLD with stall=0 SHALL discard the held instruction without counting it.
REQ-026 The memory is combinational/read-only; an abandoned request (imem_req dropped or imem_addr changed before imem_ready) SHALL be legal.
REQ-027 PC 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000.
REQ-028 Minimum issue interval SHALL be 2 cycles per instruction (FETCH plus HOLD).

Reset
REQ-029 On Reset=1 at a clock edge: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, inst_count=0, fault=0.
REQ-030 Reset SHALL override every other input in every state, including FAULT and mid-wait FETCH.

Configuration
REQ-031 With macro FETCH_ALIGN_CHECK_EN defined: a redirect with redirect_pc[1:0]!=2'b00 SHALL move to FAULT; in FAULT, fault=1, imem_req=0, inst_valid=0, redirects are ignored, and only Reset exits.
REQ-032 Without FETCH_ALIGN_CHECK_EN: redirect_pc[1:0] SHALL be forced to 2'b00, fault SHALL be constant 0, and FAULT SHALL be unreachable.

Verification
REQ-033 Reset, imem_ready tied 1, stall 0: imem_addr sequence 0,4,8; inst_valid pulses every 2nd cycle; inst_count=3 after 3 consumes.
REQ-034 imem_ready delayed 3 cycles at addr 0x10: imem_req held with imem_addr=0x10 for 4 cycles; inst_pc=0x10.
REQ-035 stall=1 for 5 cycles in HOLD with inst=0x8C010004: inst and inst_pc stable, no new imem_req, inst_count unchanged.
REQ-036 redirect_valid with redirect_pc=0x40 in the same cycle as imem_ready: data dropped, next imem_addr=0x40, inst_count unchanged.
REQ-037 With FETCH_ALIGN_CHECK_EN, redirect_pc=0x42: fault=1, imem_req=0 until Reset; without the macro, next imem_addr=0x40.
REQ-038 Redirect to 0xFFFF_FFFC, then one consume: next imem_addr=0x0000_0000.
